// File: rtl/sfu_out_stream.sv
// sfu_out_stream: output framing stage of the SFU path.
// Gathered NUM_CH x 16-bit vectors are buffered in a small first-word-fall-through
// FIFO and driven out as an AXI-stream, with tlast on the final beat of each frame.
// Optional build macro: SFU_OUT_STALL_CNT_EN adds a saturating output stall counter.
module sfu_out_stream #(
  parameter int NUM_CH = 32,
  parameter int DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic [7:0]           params_step_num,
  input  logic                 s_sfu_valid,
  output logic                 s_sfu_ready,
  input  logic [NUM_CH*16-1:0] s_sfu_data,
  output logic                 m_sfu_axis_tvalid,
  input  logic                 m_sfu_axis_tready,
  output logic [NUM_CH*16-1:0] m_sfu_axis_tdata,
  output logic                 m_sfu_axis_tlast,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          frame_cnt
`ifdef SFU_OUT_STALL_CNT_EN
  ,output logic [31:0]         stall_cnt
`endif
);

  localparam int DW = NUM_CH * 16;
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [8:0]  n_target;
  logic [8:0]  wr_cnt;
  logic [DW:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [DW:0] head;
  logic        fifo_empty, fifo_full;
  logic        wr_en, rd_en, wr_last, head_last, start_acc;

  // FIFO status from extra-MSB pointers: equal means empty, MSB-only difference means full
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head       = mem[rd_ptr[AW-1:0]];
  assign head_last  = head[DW];

  assign start_acc  = (state == IDLE) && cfg_start;
  assign wr_en      = s_sfu_valid && s_sfu_ready;
  assign rd_en      = m_sfu_axis_tvalid && m_sfu_axis_tready;
  assign wr_last    = (wr_cnt == (n_target - 9'd1));

  // Outputs are gated by FIFO occupancy so stale entries never leak out after a flush
  assign s_sfu_ready       = (state == RUN) && !fifo_full;
  assign busy              = (state != IDLE);
  assign m_sfu_axis_tvalid = !fifo_empty;
  assign m_sfu_axis_tdata  = fifo_empty ? '0 : head[DW-1:0];
  assign m_sfu_axis_tlast  = fifo_empty ? 1'b0 : head_last;

  // Next-state logic: accept a frame, collect N beats, then wait for the tlast beat to leave
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_start) state_nxt = RUN;
      RUN:     if (wr_en && wr_last) state_nxt = DRAIN;
      DRAIN:   if (rd_en && head_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus frame target and write-beat counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      n_target <= 9'd0;
      wr_cnt   <= 9'd0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        n_target <= (params_step_num == 8'd0) ? 9'd256 : {1'b0, params_step_num};
        wr_cnt   <= 9'd0;
      end else if (wr_en) begin
        wr_cnt <= wr_cnt + 9'd1;
      end
    end
  end

  // FIFO storage: each entry carries the data vector and its frame-last flag
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {wr_last, s_sfu_data};
  end

  // FIFO pointers; reset flushes whatever partial frame was buffered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Frame completion: one-cycle done pulse and wrapping frame counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done      <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      done <= (state == DRAIN) && rd_en && head_last;
      if ((state == DRAIN) && rd_en && head_last) frame_cnt <= frame_cnt + 16'd1;
    end
  end

`ifdef SFU_OUT_STALL_CNT_EN
  // Count cycles where the downstream holds off a valid beat; saturates, cleared per frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 32'd0;
    end else if (start_acc) begin
      stall_cnt <= 32'd0;
    end else if (m_sfu_axis_tvalid && !m_sfu_axis_tready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sfu_out_stream.sv
// tb_sfu_out_stream: directed self-checking bench for sfu_out_stream.
// Beats are recorded by a negedge monitor and compared against hand-derived frames.
module tb_sfu_out_stream;

  localparam int NUM_CH = 32;
  localparam int DEPTH  = 4;
  localparam int DW     = NUM_CH * 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_start = 1'b0;
  logic [7:0]    params_step_num = 8'd0;
  logic          s_sfu_valid = 1'b0;
  logic          s_sfu_ready;
  logic [DW-1:0] s_sfu_data = '0;
  logic          m_sfu_axis_tvalid;
  logic          m_sfu_axis_tready = 1'b0;
  logic [DW-1:0] m_sfu_axis_tdata;
  logic          m_sfu_axis_tlast;
  logic          busy;
  logic          done;
  logic [15:0]   frame_cnt;
`ifdef SFU_OUT_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;

  logic [DW-1:0] out_data_q[$];
  logic          out_last_q[$];
  int            out_cyc_q[$];
  int            in_cyc_q[$];

  sfu_out_stream #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .cfg_start         (cfg_start),
    .params_step_num   (params_step_num),
    .s_sfu_valid       (s_sfu_valid),
    .s_sfu_ready       (s_sfu_ready),
    .s_sfu_data        (s_sfu_data),
    .m_sfu_axis_tvalid (m_sfu_axis_tvalid),
    .m_sfu_axis_tready (m_sfu_axis_tready),
    .m_sfu_axis_tdata  (m_sfu_axis_tdata),
    .m_sfu_axis_tlast  (m_sfu_axis_tlast),
    .busy              (busy),
    .done              (done),
    .frame_cnt         (frame_cnt)
`ifdef SFU_OUT_STALL_CNT_EN
    ,.stall_cnt        (stall_cnt)
`endif
  );

  // Free-running clock and cycle counter
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor at the falling edge: a handshake seen here completes at the next rising edge
  always @(negedge clk) begin
    if (rst && m_sfu_axis_tvalid && m_sfu_axis_tready) begin
      out_data_q.push_back(m_sfu_axis_tdata);
      out_last_q.push_back(m_sfu_axis_tlast);
      out_cyc_q.push_back(cyc);
    end
    if (rst && s_sfu_valid && s_sfu_ready) in_cyc_q.push_back(cyc);
    if (done) done_cnt++;
  end

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Lane i of beat value v carries v*64+i so lane order and beat order are both visible
  function automatic logic [DW-1:0] make_data(input int v);
    logic [DW-1:0] d;
    for (int i = 0; i < NUM_CH; i++) d[16*i +: 16] = 16'(v * 64 + i);
    return d;
  endfunction

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    out_data_q.delete();
    out_last_q.delete();
    out_cyc_q.delete();
    in_cyc_q.delete();
  endtask

  task automatic applyStimulus(input logic [7:0] step);
    cfg_start       = 1'b1;
    params_step_num = step;
    next_cycle();
    cfg_start       = 1'b0;
  endtask

  task automatic send_beats(input int n, input int base);
    logic hs;
    int   t;
    for (int k = 0; k < n; k++) begin
      s_sfu_valid = 1'b1;
      s_sfu_data  = make_data(base + k);
      hs = 1'b0;
      t  = 0;
      while (!hs && t < 500) begin
        @(negedge clk);
        hs = s_sfu_ready;
        next_cycle();
        t++;
      end
      if (!hs) begin
        checkOutput("send_timeout", 0, 1);
        s_sfu_valid = 1'b0;
        return;
      end
    end
    s_sfu_valid = 1'b0;
  endtask

  task automatic wait_done();
    int start_cnt;
    int t;
    start_cnt = done_cnt;
    t = 0;
    while (done_cnt == start_cnt && t < 3000) begin
      next_cycle();
      t++;
    end
    if (done_cnt == start_cnt) checkOutput("done_timeout", 0, 1);
  endtask

  task automatic check_frame(input int n, input int base);
    int m;
    checkOutput("out_count", out_data_q.size(), n);
    m = (out_data_q.size() < n) ? out_data_q.size() : n;
    for (int k = 0; k < m; k++) begin
      checkOutput($sformatf("beat%0d_data", k), out_data_q[k], make_data(base + k));
      checkOutput($sformatf("beat%0d_last", k), out_last_q[k], (k == n - 1));
    end
  endtask

  // Directed test sequence
  initial begin
    int d0;

    repeat (3) next_cycle();
    checkOutput("rst_tvalid", m_sfu_axis_tvalid, 0);
    checkOutput("rst_ready", s_sfu_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_frame_cnt", frame_cnt, 0);
    checkOutput("rst_tdata", m_sfu_axis_tdata, 0);
    checkOutput("rst_tlast", m_sfu_axis_tlast, 0);
    rst = 1'b1;
    next_cycle();

    // Reset in the middle of a 5-beat frame after 3 beats are buffered
    clear_q();
    m_sfu_axis_tready = 1'b0;
    applyStimulus(8'd5);
    send_beats(3, 100);
    checkOutput("mid_tvalid", m_sfu_axis_tvalid, 1);
    checkOutput("mid_busy", busy, 1);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("arst_tvalid", m_sfu_axis_tvalid, 0);
    checkOutput("arst_tdata", m_sfu_axis_tdata, 0);
    checkOutput("arst_tlast", m_sfu_axis_tlast, 0);
    checkOutput("arst_ready", s_sfu_ready, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_frame_cnt", frame_cnt, 0);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    checkOutput("post_rst_tvalid", m_sfu_axis_tvalid, 0);

    // 4-beat frame, tready held high, back-to-back input
    clear_q();
    m_sfu_axis_tready = 1'b1;
    d0 = done_cnt;
    applyStimulus(8'd4);
    send_beats(4, 1);
    wait_done();
    repeat (3) next_cycle();
    check_frame(4, 1);
    if (out_cyc_q.size() == 4 && in_cyc_q.size() == 4) begin
      checkOutput("first_latency", out_cyc_q[0] - in_cyc_q[0], 1);
      for (int k = 1; k < 4; k++)
        checkOutput($sformatf("consec%0d", k), out_cyc_q[k] - out_cyc_q[0], k);
    end else begin
      checkOutput("t1_cycle_log", in_cyc_q.size(), 4);
    end
    checkOutput("t1_done_pulses", done_cnt - d0, 1);
    checkOutput("t1_frame_cnt", frame_cnt, 1);
    checkOutput("t1_busy", busy, 0);

    // 8-beat frame with the output blocked for 20 cycles
    clear_q();
    m_sfu_axis_tready = 1'b0;
    applyStimulus(8'd8);
    fork
      send_beats(8, 20);
      begin
        repeat (20) next_cycle();
        checkOutput("t2_accepts", in_cyc_q.size(), DEPTH);
        checkOutput("t2_ready_low", s_sfu_ready, 0);
        checkOutput("t2_tvalid", m_sfu_axis_tvalid, 1);
        checkOutput("t2_head_hold", m_sfu_axis_tdata, make_data(20));
        m_sfu_axis_tready = 1'b1;
      end
    join
    wait_done();
    check_frame(8, 20);
    checkOutput("t2_frame_cnt", frame_cnt, 2);

    // step_num=0 frame of 256 beats, then a held beat that waits for the next start
    clear_q();
    applyStimulus(8'd0);
    send_beats(256, 300);
    s_sfu_valid = 1'b1;
    s_sfu_data  = make_data(556);
    wait_done();
    repeat (4) next_cycle();
    checkOutput("t3_accepts", in_cyc_q.size(), 256);
    checkOutput("t3_ready_low", s_sfu_ready, 0);
    checkOutput("t3_frame_cnt", frame_cnt, 3);
    check_frame(256, 300);
    clear_q();
    applyStimulus(8'd1);
    send_beats(1, 556);
    wait_done();
    check_frame(1, 556);
    checkOutput("t3b_frame_cnt", frame_cnt, 4);

    // Start pulse during a 6-beat frame must not change its length
    clear_q();
    d0 = done_cnt;
    applyStimulus(8'd6);
    send_beats(2, 700);
    applyStimulus(8'd2);
    send_beats(4, 702);
    wait_done();
    repeat (2) next_cycle();
    check_frame(6, 700);
    checkOutput("t4_done_pulses", done_cnt - d0, 1);
    checkOutput("t4_frame_cnt", frame_cnt, 5);

`ifdef SFU_OUT_STALL_CNT_EN
    // Stall counter: 7 blocked cycles, then cleared by the next accepted start
    clear_q();
    m_sfu_axis_tready = 1'b0;
    applyStimulus(8'd1);
    checkOutput("stall_clear0", stall_cnt, 0);
    send_beats(1, 800);
    repeat (7) next_cycle();
    checkOutput("stall_7", stall_cnt, 7);
    m_sfu_axis_tready = 1'b1;
    wait_done();
    checkOutput("stall_hold", stall_cnt, 7);
    applyStimulus(8'd1);
    checkOutput("stall_clear1", stall_cnt, 0);
    send_beats(1, 801);
    wait_done();
    checkOutput("stall_frame_cnt", frame_cnt, 7);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sfu_out_stream.md
Name: sfu_out_stream

Overview:
Output framing stage of the SFU path. It accepts gathered NUM_CH x 16-bit result vectors from the SFU gather stage, buffers them in a small FIFO, and drives them out as an AXI-stream (m_sfu_axis_*) toward the output DMA. It also marks tlast on the final beat of each step frame, whose length comes from params_step_num. This output stream is the interface the SFU output checker observes.

Parameters:
NUM_CH, 32, number of 16-bit lanes per beat
DEPTH, 4, FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
cfg_start  in  1  one-cycle pulse that starts a frame
params_step_num  in  8  beats per frame, latched at cfg_start; 0 means 256
s_sfu_valid  in  1  input beat valid
s_sfu_ready  out  1  input beat ready
s_sfu_data  in  NUM_CH*16  input vector, lane i at bits [16i+15:16i]
m_sfu_axis_tvalid  out  1  output valid
m_sfu_axis_tready  in  1  output ready
m_sfu_axis_tdata  out  NUM_CH*16  output vector, unmodified lane order
m_sfu_axis_tlast  out  1  last beat of frame
busy  out  1  FSM not in IDLE
done  out  1  one-cycle pulse, frame fully drained
frame_cnt  out  16  completed frames, wraps at 0xFFFF->0

Behaviour:
- Reset (rst=0, async assert, sync deassert into logic): FSM=IDLE; FIFO empty; counters 0; all outputs 0.
- FSM states IDLE, RUN, DRAIN.
  - IDLE -> RUN on cfg_start. Latch beat target N = (params_step_num==0) ? 256 : params_step_num into a 9-bit register. Clear the write counter.
  - RUN: s_sfu_ready = !fifo_full. Each input handshake writes {data, last} into the FIFO, with last = (wr_cnt == N-1), and increments wr_cnt. When the write with last=1 occurs, go to DRAIN in the next cycle.
  - DRAIN: s_sfu_ready=0. When the output handshake with tlast=1 occurs, pulse done for the following cycle, increment frame_cnt, and go to IDLE.
- s_sfu_ready is 0 in IDLE and DRAIN. Input valid in those states is not consumed and must be held by the source.
- cfg_start while busy=1 is ignored; the latched N is unchanged.
- FIFO is first-word-fall-through. m_sfu_axis_tvalid = !fifo_empty, and tdata/tlast are driven from the head entry. Latency from input handshake to tvalid is 1 cycle when the FIFO is empty.
- Output beat completes when tvalid && tready. tdata/tlast are stable while tvalid=1 and tready=0.
- A simultaneous write and read when full is not allowed, because ready is based on full. A simultaneous write and read when non-full keeps the count unchanged. Read and write pointers are log2(DEPTH)+1 bits wide with wrap-around.
- Throughput is 1 beat/cycle sustained when tready is held at 1.
- An output tlast handshake in the same cycle as a new cfg_start: the FSM returns to IDLE first, so that cfg_start is ignored. A new start must arrive on or after the cycle done is asserted.
- Reset mid-frame flushes the FIFO and discards the partial frame; frame_cnt is not incremented.

Optional Feature:
SFU_OUT_STALL_CNT_EN
- Defined: adds output port stall_cnt (32 bits, reset 0). It increments on every cycle with m_sfu_axis_tvalid=1 and m_sfu_axis_tready=0, saturates at 0xFFFFFFFF, and clears on cfg_start accepted from IDLE.
- Undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- step_num=4, tready=1, 4 back-to-back inputs with values 1..4 -> 4 output beats in consecutive cycles starting 1 cycle after the first input; tlast only on value 4; done pulses once; frame_cnt=1.
- step_num=8, tready=0 for 20 cycles then 1 -> s_sfu_ready drops after DEPTH=4 accepts; all 8 beats arrive in order with no loss; tlast on beat 8.
- step_num=0 -> exactly 256 beats accepted; tlast on beat 256; input valid held after beat 256 is not consumed until the next cfg_start.
- cfg_start pulsed mid-frame with step_num=2 during a frame of 6 -> frame still ends at beat 6; N stays 6.
- Assert rst low after 3 of 5 beats -> all outputs 0 immediately; tvalid=0; frame_cnt unchanged; a new frame after reset behaves normally.
- SFU_OUT_STALL_CNT_EN defined, tvalid high with tready low for 7 cycles -> stall_cnt=7; it clears on the next accepted cfg_start.
